viterbi_acs_sched: RTL and testbench

//  Sequencer for the shared, time-multiplexed branch-metric/ACS array of the 64-state decoder.
//  - Accepts one received symbol pair per trellis stage over a valid/ready handshake.
//  - Holds the pair stable on the BMC inputs and steps the ACS array through NUM_GROUPS butterfly groups.
//  - Waits out the ACS pipeline, commits the survivor column, and triggers traceback every TB_LEN stages or at frame end.

---
 rtl/viterbi_acs_sched.sv | 172 +++++++++++++++++
 tb/tb_viterbi_acs_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_sched.sv
// viterbi_acs_sched
//   Sequencer for the shared, time-multiplexed branch-metric/ACS array of a 64-state
//   Viterbi decoder. It accepts one received symbol pair per trellis stage and holds it
//   on the BMC inputs. It then steps the ACS array through NUM_GROUPS butterfly groups
//   and waits out the ACS pipeline. Finally it commits the survivor column and requests
//   traceback every TB_LEN stages or at frame end.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   rx_valid   rx_pair/rx_last valid
//   rx_ready   block can accept a pair (only in IDLE)
//   rx_pair    hard-decision received pair, bit0 = first code bit
//   rx_last    pair is the final symbol of a frame
//   bmc_pair   registered pair driven to all BMC instances
//   acs_en     ACS array processes group acs_grp this cycle
//   acs_grp    butterfly group index
//   surv_we    one-cycle survivor-column write strobe
//   surv_addr  survivor-memory column (stage index)
//   tb_start   one-cycle traceback request
//   tb_flush   qualifies tb_start: 1 = frame end, 0 = window full
//   tb_done    traceback finished, sampled only while waiting for it
//   busy       sequencer is not idle
//
// All outputs come straight from flops.

module viterbi_acs_sched #(
    parameter int unsigned NUM_GROUPS = 8,
    parameter int unsigned GRP_W      = 3,
    parameter int unsigned ACS_LAT    = 2,
    parameter int unsigned TB_LEN     = 32,
    parameter int unsigned STG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [1:0]       rx_pair,
    input  logic             rx_last,
    output logic [1:0]       bmc_pair,
    output logic             acs_en,
    output logic [GRP_W-1:0] acs_grp,
    output logic             surv_we,
    output logic [STG_W-1:0] surv_addr,
    output logic             tb_start,
    output logic             tb_flush,
    input  logic             tb_done,
    output logic             busy
);

    localparam int unsigned CNT_W = (ACS_LAT > 1) ? $clog2(ACS_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StTbWait} state_e;

    state_e             state_q, state_d;
    logic [1:0]         bmc_q, bmc_d;
    logic               last_q, last_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic               acs_en_q, acs_en_d;
    logic               surv_we_q, surv_we_d;
    logic               tb_start_q, tb_start_d;
    logic               tb_flush_q, tb_flush_d;
    logic               rx_ready_q, rx_ready_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        bmc_d      = bmc_q;
        last_d     = last_q;
        grp_d      = grp_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        acs_en_d   = 1'b0;
        surv_we_d  = 1'b0;
        tb_start_d = 1'b0;
        tb_flush_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_valid && rx_ready_q) begin
                    state_d  = StRun;
                    bmc_d    = rx_pair;
                    last_d   = rx_last;
                    grp_d    = '0;
                    acs_en_d = 1'b1;
                end
            end
            StRun: begin
                if (grp_q == GRP_W'(NUM_GROUPS - 1)) begin
                    state_d   = StDrain;
                    cnt_d     = '0;
                    // With a single-cycle pipeline the first drain cycle is also the last.
                    surv_we_d = (ACS_LAT == 1);
                end else begin
                    grp_d    = grp_q + 1'b1;
                    acs_en_d = 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == CNT_W'(ACS_LAT - 1)) begin
                    // A frame end on the wrap stage still yields a single flush request.
                    if ((stage_q == STG_W'(TB_LEN - 1)) || last_q) begin
                        stage_d    = '0;
                        tb_start_d = 1'b1;
                        tb_flush_d = last_q;
                        state_d    = StTbWait;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    surv_we_d = (cnt_q == CNT_W'(ACS_LAT - 2));
                end
            end
            StTbWait: begin
                // The first cycle here is the tb_start cycle, so a same-cycle done counts.
                if (tb_done) begin
                    state_d = StIdle;
                    last_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        rx_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bmc_q      <= '0;
            last_q     <= 1'b0;
            grp_q      <= '0;
            cnt_q      <= '0;
            stage_q    <= '0;
            acs_en_q   <= 1'b0;
            surv_we_q  <= 1'b0;
            tb_start_q <= 1'b0;
            tb_flush_q <= 1'b0;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bmc_q      <= bmc_d;
            last_q     <= last_d;
            grp_q      <= grp_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            acs_en_q   <= acs_en_d;
            surv_we_q  <= surv_we_d;
            tb_start_q <= tb_start_d;
            tb_flush_q <= tb_flush_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign bmc_pair  = bmc_q;
    assign acs_en    = acs_en_q;
    assign acs_grp   = grp_q;
    assign surv_we   = surv_we_q;
    assign surv_addr = stage_q;
    assign tb_start  = tb_start_q;
    assign tb_flush  = tb_flush_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Bench for viterbi_acs_sched with default parameters. A table of stage records
// (pair, last, traceback delay, tb_done noise, expected column/traceback) is applied
// and every cycle of each stage is compared. Hand-written sequences cover the reset
// cases and a held rx_valid scoreboard.

module tb_viterbi_acs_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic       rx_ready;
    logic [1:0] rx_pair;
    logic       rx_last;
    logic [1:0] bmc_pair;
    logic       acs_en;
    logic [2:0] acs_grp;
    logic       surv_we;
    logic [4:0] surv_addr;
    logic       tb_start;
    logic       tb_flush;
    logic       tb_done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    viterbi_acs_sched dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_pair   (rx_pair),
        .rx_last   (rx_last),
        .bmc_pair  (bmc_pair),
        .acs_en    (acs_en),
        .acs_grp   (acs_grp),
        .surv_we   (surv_we),
        .surv_addr (surv_addr),
        .tb_start  (tb_start),
        .tb_flush  (tb_flush),
        .tb_done   (tb_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] pair;
        logic       last;
        int         delay;   // TB_WAIT cycles before tb_done rises
        logic       noise;   // hold tb_done high outside TB_WAIT
        logic [4:0] addr;    // expected surv_addr
        logic       tb;      // expected tb_start after this stage
        logic       flush;   // expected tb_flush with it
    } vec_t;

    vec_t vecs[39];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_stage(input vec_t v);
        chk("ready_idle", rx_ready, 1);
        chk("busy_idle", busy, 0);
        rx_valid = 1'b1;
        rx_pair  = v.pair;
        rx_last  = v.last;
        tb_done  = v.noise;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("acs_en", acs_en, (k <= 8));
            if (k <= 8) chk("acs_grp", acs_grp, k - 1);
            chk("bmc_pair", bmc_pair, v.pair);
            chk("ready_busy", rx_ready, 0);
            chk("busy_run", busy, 1);
            chk("surv_we", surv_we, (k == 10));
            if (k == 10) chk("surv_addr", surv_addr, v.addr);
            chk("tb_start_early", tb_start, 0);
            if (k == 1) begin
                rx_valid = 1'b0;
                rx_last  = 1'b0;
                rx_pair  = ~v.pair;  // bmc_pair must not follow
            end
        end
        @(negedge clk);
        chk("tb_start", tb_start, v.tb);
        chk("ready_after", rx_ready, !v.tb);
        chk("surv_we_after", surv_we, 0);
        if (v.tb) begin
            chk("tb_flush", tb_flush, v.flush);
            tb_done = (v.delay == 0);
            for (int j = 0; j < v.delay; j++) begin
                @(negedge clk);
                chk("ready_tbwait", rx_ready, 0);
                chk("busy_tbwait", busy, 1);
                chk("tb_start_once", tb_start, 0);
            end
            tb_done = 1'b1;
            @(negedge clk);
            chk("ready_tbdone", rx_ready, 1);
            chk("busy_tbdone", busy, 0);
            tb_done = 1'b0;
        end
    endtask

    logic [1:0] sent_q[$];
    logic [1:0] got_q[$];

    initial begin
        int         nsent;
        int         nwe;
        logic       pend;
        logic [1:0] cur;

        // Stage table: 32 back-to-back with tb_done tied high, then a frame ending
        // on stage 5 with a withheld tb_done, then one more stage to show the reset column.
        for (int i = 0; i < 32; i++) begin
            vecs[i] = '{pair: 2'(i), last: 1'b0, delay: 0, noise: 1'b1,
                        addr: 5'(i), tb: (i == 31), flush: 1'b0};
        end
        vecs[0].pair = 2'b10;
        for (int i = 32; i < 38; i++) begin
            vecs[i] = '{pair: 2'(i + 1), last: (i == 37), delay: (i == 37) ? 20 : 0,
                        noise: (i == 37), addr: 5'(i - 32), tb: (i == 37), flush: (i == 37)};
        end
        vecs[38] = '{pair: 2'b01, last: 1'b0, delay: 0, noise: 1'b0,
                     addr: 5'd0, tb: 1'b0, flush: 1'b0};

        rst = 1'b1; rx_valid = 1'b0; rx_pair = 2'b00; rx_last = 1'b0; tb_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rx_ready, 1);
        chk("rst_bmc", bmc_pair, 0);
        chk("rst_acs_en", acs_en, 0);
        chk("rst_grp", acs_grp, 0);
        chk("rst_we", surv_we, 0);
        chk("rst_addr", surv_addr, 0);
        chk("rst_tb_start", tb_start, 0);
        chk("rst_tb_flush", tb_flush, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Reset while the array is on group 3: work is dropped.
        rx_valid = 1'b1; rx_pair = 2'b11; rx_last = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_grp", acs_grp, 3);
        chk("mid_en", acs_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_ready", rx_ready, 1);
        chk("mid_en_off", acs_en, 0);
        chk("mid_busy", busy, 0);
        nwe = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (surv_we || tb_start || acs_en) nwe++;
        end
        chk("mid_no_strobes", nwe, 0);

        foreach (vecs[i]) run_stage(vecs[i]);

        // rx_valid held high across busy periods; one pair per IDLE visit.
        nsent = 0; pend = 1'b0; cur = 2'b01;
        rx_valid = 1'b1; rx_pair = cur; rx_last = 1'b0; tb_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (acs_en && acs_grp == 3'd0) got_q.push_back(bmc_pair);
            tb_done = tb_start;
            if (pend) begin
                pend = 1'b0;
                if (nsent == 5) begin
                    rx_valid = 1'b0;
                end else begin
                    cur     = cur + 2'd1;
                    rx_pair = cur;
                    rx_last = (nsent == 1);
                end
            end
            if (rx_ready && rx_valid) begin
                sent_q.push_back(cur);
                nsent++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        chk("sb_sent", nsent, 5);
        chk("sb_got", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size() && i < sent_q.size()) chk("sb_pair", got_q[i], sent_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
